// File: rtl/serial_tx_pkg.sv
// Shared types and line levels for the serial byte transmitter.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        PARITY
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: single-cycle tick when the counter is all-ones,
// msb is the divider heartbeat.
module tick_gen #(
    parameter int DIV_BITS = 24
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick,
    output logic msb
);

    logic [DIV_BITS-1:0] cntr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cntr_q <= '0;
        else        cntr_q <= cntr_q + 1'b1;
    end

    assign tick = &cntr_q;
    assign msb  = cntr_q[DIV_BITS-1];

endmodule

// File: rtl/serial_byte_tx.sv
// Parallel-to-serial byte transmitter: start, LSB-first data, stop, one bit per tick.
// Build with SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_byte_tx
    import serial_tx_pkg::*;
#(
    parameter int DIV_BITS = 24,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] D,
    input  logic              load_n,
    output logic              tx,
    output logic              busy,
    output logic [DATA_W-1:0] led,
    output logic              clk_alert
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic              tick;
    logic              sync1_q, sync2_q, req;
    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
`ifdef SERIAL_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    tick_gen #(.DIV_BITS(DIV_BITS)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .msb   (clk_alert)
    );

    // Synchronizer idles at 1 so reset never looks like a request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= load_n;
            sync2_q <= sync1_q;
        end
    end

    assign req = !sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            led_q   <= '0;
            idx_q   <= '0;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            led_q   <= led_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        led_d   = led_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (tick) begin
            case (state_q)
                IDLE: begin
                    tx_d = IDLE_LEVEL;
                    if (req) begin
                        shreg_d = D;
                        led_d   = D;
                        tx_d    = START_LEVEL;
                        busy_d  = 1'b1;
                        idx_d   = '0;
                        state_d = START;
`ifdef SERIAL_TX_PARITY_EN
                        par_d   = ^D;
`endif
                    end
                end
                START: begin
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    state_d = DATA;
                end
                DATA: begin
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = PARITY;
`else
                        tx_d    = STOP_LEVEL;
                        state_d = STOP;
`endif
                    end else begin
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    tx_d    = STOP_LEVEL;
                    state_d = STOP;
                end
`endif
                STOP: begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: begin
                    tx_d    = IDLE_LEVEL;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign led  = led_q;

endmodule

// File: tb/tb_serial_byte_tx.sv
// Scoreboard bench for serial_byte_tx with an 8-clk bit period; expected frames are
// queued by the stimulus and consumed by a monitor that triggers on busy rising.
module tb_serial_byte_tx;

    localparam int DB = 3;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FL = 11;
    localparam logic [10:0] EXP_A5 = 11'b1_0_10100101_0;
    localparam logic [10:0] EXP_3C = 11'b1_0_00111100_0;
    localparam logic [10:0] EXP_01 = 11'b1_1_00000001_0;
    localparam logic [10:0] EXP_0F = 11'b1_0_00001111_0;
    localparam logic [10:0] EXP_07 = 11'b1_1_00000111_0;
    localparam logic [10:0] EXP_03 = 11'b1_0_00000011_0;
`else
    localparam int FL = 10;
    localparam logic [10:0] EXP_A5 = 11'b0_1_10100101_0;
    localparam logic [10:0] EXP_3C = 11'b0_1_00111100_0;
    localparam logic [10:0] EXP_01 = 11'b0_1_00000001_0;
    localparam logic [10:0] EXP_0F = 11'b0_1_00001111_0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_n = 1'b1;
    logic [7:0] D = 8'h00;
    logic       tx, busy, clk_alert;
    logic [7:0] led;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames = 0;
    int last_end = 0;
    int b2b_seen = 0;
    bit b2b = 1'b0;
    logic [10:0] expq[$];

    serial_byte_tx #(.DIV_BITS(DB), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .D         (D),
        .load_n    (load_n),
        .tx        (tx),
        .busy      (busy),
        .led       (led),
        .clk_alert (clk_alert)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [10:0] e);
        D = d;
        expq.push_back(e);
        load_n = 1'b0;
        repeat (16) @(negedge clk);
        load_n = 1'b1;
    endtask

    initial begin : monitor
        logic        bp;
        logic [10:0] e;
        bit          abort;
        int          hi;
        bp = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) bp = 1'b0;
            else if (busy && !bp) begin
                frames++;
                if (b2b && b2b_seen > 0) chk("b2b_gap", cyc - last_end, 8);
                if (b2b) b2b_seen++;
                if (expq.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    e = '1;
                end else e = expq.pop_front();
                abort = 1'b0;
                hi = 0;
                for (int p = 0; p < FL && !abort; p++) begin
                    for (int k = 0; k < 8 && !abort; k++) begin
                        if (!rst_n) abort = 1'b1;
                        else begin
                            if (k == 0) chk($sformatf("bit%0d", p), tx, e[p]);
                            else if (tx !== e[p]) chk($sformatf("hold%0d", p), tx, e[p]);
                            if (busy) hi++;
                            @(negedge clk);
                        end
                    end
                end
                if (!abort && rst_n) begin
                    chk("busy_len", hi, FL * 8);
                    chk("busy_fall", busy, 0);
                    last_end = cyc;
                end
                bp = 1'b0;
            end else bp = busy;
        end
    end

    initial begin : stim
        int   bad, bad_ca, ntog, last_t, f0;
        logic ca;

        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_led", led, 0);
        chk("rst_alert", clk_alert, 0);
        rst_n = 1'b1;

        bad = 0; bad_ca = 0; ntog = 0; last_t = -1; ca = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || led !== 8'h00) bad++;
            if (clk_alert !== ca) begin
                if (last_t >= 0 && cyc - last_t != 4) bad_ca++;
                last_t = cyc;
                ca = clk_alert;
                ntog++;
            end
        end
        chk("idle_lines", bad, 0);
        chk("alert_period", bad_ca, 0);
        chk("alert_toggles", ntog, 50);

        send(8'hA5, EXP_A5);
        repeat (100) @(negedge clk);
        chk("led_A5", led, 8'hA5);
        chk("idle_after_A5", {busy, tx}, 2'b01);

        D = 8'h3C;
        repeat (3) expq.push_back(EXP_3C);
        b2b = 1'b1;
        b2b_seen = 0;
        f0 = frames;
        load_n = 1'b0;
        for (int i = 0; i < 400 && frames < f0 + 3; i++) @(negedge clk);
        load_n = 1'b1;
        chk("b2b_frames", frames - f0, 3);
        repeat (100) @(negedge clk);
        b2b = 1'b0;
        chk("led_3C", led, 8'h3C);

        send(8'h01, EXP_01);
        D = 8'hFF;
        repeat (100) @(negedge clk);
        chk("led_01", led, 8'h01);

        D = 8'h0F;
        expq.push_back(EXP_0F);
        load_n = 1'b0;
        for (int i = 0; i < 40 && !busy; i++) @(negedge clk);
        load_n = 1'b1;
        chk("rst_frame_started", busy, 1);
        repeat (44) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        chk("no_frame_after_rst", bad, 0);

`ifdef SERIAL_TX_PARITY_EN
        send(8'h07, EXP_07);
        repeat (100) @(negedge clk);
        chk("led_07", led, 8'h07);
        send(8'h03, EXP_03);
        repeat (100) @(negedge clk);
        chk("led_03", led, 8'h03);
`endif

        chk("queue_empty", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
